mem_read_arbiter_rr: RTL and testbench

- Shares one pipelined, read-only memory port among N_CLIENTS directly-mapped caches.
- Sits directly downstream of the caches' miss ports: each client drives addr_out_valid/addr_out into this block and receives addr_out_ready/data_in from it.
- Round-robin arbitration. At most one memory issue per cycle.
- Requests from different clients are pipelined across the fixed MEM_LATENCY.

---
 rtl/mem_read_arbiter_rr_if.sv | 24 ++
 rtl/mem_read_arbiter_rr.sv | 95 +++++++++
 tb/tb_mem_read_arbiter_rr.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_arbiter_rr_if.sv
// rtl/mem_read_arbiter_rr_if.sv - client miss ports and shared memory read port of the round-robin read arbiter
interface mem_read_arbiter_rr_if #(
   parameter int N_CLIENTS  = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DWIDTH     = 20
);
   logic [N_CLIENTS-1:0]            req_valid;
   logic [N_CLIENTS*ADDR_WIDTH-1:0] req_addr;
   logic [N_CLIENTS-1:0]            req_ready;
   logic [DWIDTH-1:0]               req_data;
   logic                            mem_en;
   logic [ADDR_WIDTH-1:0]           mem_addr;
   logic [DWIDTH-1:0]               mem_rdata;

   modport master (
      output req_valid, req_addr, mem_rdata,
      input  req_ready, req_data, mem_en, mem_addr
   );

   modport slave (
      input  req_valid, req_addr, mem_rdata,
      output req_ready, req_data, mem_en, mem_addr
   );
endinterface

// File: rtl/mem_read_arbiter_rr.sv
// rtl/mem_read_arbiter_rr.sv - round-robin sharing of one pipelined read-only memory port among cache miss ports
module mem_read_arbiter_rr #(
   parameter int N_CLIENTS   = 4,
   parameter int ADDR_WIDTH  = 16,
   parameter int DWIDTH      = 20,
   parameter int MEM_LATENCY = 2
) (
   input logic                  clk,
   input logic                  rst,
   mem_read_arbiter_rr_if.slave bus
);
   localparam int PW = $clog2(N_CLIENTS);

   logic [PW-1:0]          ptr;
   logic [PW-1:0]          gnt;
   logic [PW-1:0]          scan_idx;
   logic                   gnt_any;
   logic [N_CLIENTS-1:0]   busy;
   logic [N_CLIENTS-1:0]   eligible;
   logic [N_CLIENTS-1:0]   gnt_onehot;
   logic [N_CLIENTS-1:0]   done_mask;
   logic [N_CLIENTS-1:0]   ready_raw;
   logic [ADDR_WIDTH-1:0]  gnt_addr;
   logic [MEM_LATENCY:1]   tag_vld;
   logic [PW-1:0]          tag_id [1:MEM_LATENCY];

   assign eligible = bus.req_valid & ~busy;

   always_comb begin
      gnt      = '0;
      gnt_any  = 1'b0;
      scan_idx = '0;
      for (int k = 1; k <= N_CLIENTS; k++) begin
         scan_idx = PW'((int'(ptr) + k) % N_CLIENTS);
         if (!gnt_any && eligible[scan_idx]) begin
            gnt     = scan_idx;
            gnt_any = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_onehot = '0;
      gnt_addr   = '0;
      done_mask  = '0;
      for (int i = 0; i < N_CLIENTS; i++) begin
         if (gnt_any && gnt == PW'(i)) begin
            gnt_onehot[i] = 1'b1;
            gnt_addr      = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
         // The last stage marks the data cycle; busy drops at its end.
         if (tag_vld[MEM_LATENCY] && tag_id[MEM_LATENCY] == PW'(i))
            done_mask[i] = 1'b1;
      end
   end

   generate
      if (MEM_LATENCY == 1) begin : g_ready_now
         assign ready_raw = gnt_onehot;
      end else begin : g_ready_pipe
         always_comb begin
            ready_raw = '0;
            for (int i = 0; i < N_CLIENTS; i++)
               if (tag_vld[MEM_LATENCY-1] && tag_id[MEM_LATENCY-1] == PW'(i))
                  ready_raw[i] = 1'b1;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= PW'(N_CLIENTS - 1);
         busy    <= '0;
         tag_vld <= '0;
         for (int k = 1; k <= MEM_LATENCY; k++)
            tag_id[k] <= '0;
      end else begin
         if (gnt_any)
            ptr <= gnt;
         busy       <= (busy & ~done_mask) | gnt_onehot;
         tag_vld[1] <= gnt_any;
         tag_id[1]  <= gnt;
         for (int k = 2; k <= MEM_LATENCY; k++) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_id[k]  <= tag_id[k-1];
         end
      end
   end

   // Gate combinational outputs so nothing leaks out while reset is held.
   assign bus.mem_en    = gnt_any & ~rst;
   assign bus.mem_addr  = rst ? '0 : gnt_addr;
   assign bus.req_ready = rst ? '0 : ready_raw;
   assign bus.req_data  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_read_arbiter_rr.sv
// tb/tb_mem_read_arbiter_rr.sv - scoreboard bench for mem_read_arbiter_rr at MEM_LATENCY 2 and 1
module tb_mem_read_arbiter_rr;
   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 20;

   typedef struct { int client; logic [AW-1:0] addr; } iss_t;
   typedef struct { int client; logic [AW-1:0] addr; int due; } rdy_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   logic [N-1:0] hold_mask = '0;
   iss_t iss_q[$];
   rdy_t rdy_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_read_arbiter_rr_if #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DWIDTH(DW)) bus ();
   mem_read_arbiter_rr_if #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DWIDTH(DW)) bus1 ();

   mem_read_arbiter_rr #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DWIDTH(DW), .MEM_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave));
   mem_read_arbiter_rr #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DWIDTH(DW), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));

   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      if (a == 16'h0040) return 20'hABCDE;
      return {a ^ 16'hC3A5, a[3:0] ^ 4'h9};
   endfunction

   // Memory models: data returns MEM_LATENCY cycles after the mem_en cycle.
   logic [DW-1:0] mem_pipe [0:1];
   logic [DW-1:0] mem1_pipe;
   always @(posedge clk) begin
      mem_pipe[0] <= bus.mem_en ? mem_fn(bus.mem_addr) : '0;
      mem_pipe[1] <= mem_pipe[0];
      mem1_pipe   <= bus1.mem_en ? mem_fn(bus1.mem_addr) : '0;
   end
   assign bus.mem_rdata  = mem_pipe[1];
   assign bus1.mem_rdata = mem1_pipe;

   always @(negedge clk) begin
      iss_t         e;
      logic [N-1:0] exp_rdy;
      if (rst) begin
         rdy_q.delete();
         vectors++;
         if (bus.mem_en !== 1'b0 || bus.mem_addr !== '0 || bus.req_ready !== '0) begin
            miscompares++;
            $display("FAIL sb_reset_out: mem_en=%b mem_addr=%h req_ready=%b, required 0 0000 0000",
                     bus.mem_en, bus.mem_addr, bus.req_ready);
         end
      end else begin
         if (bus.mem_en === 1'b1) begin
            vectors++;
            if (iss_q.size() == 0) begin
               miscompares++;
               $display("FAIL sb_unexpected_issue: cycle %0d mem_addr=%h, required no issue", cyc, bus.mem_addr);
            end else begin
               e = iss_q.pop_front();
               if (bus.mem_addr !== e.addr) begin
                  miscompares++;
                  $display("FAIL sb_issue_addr: cycle %0d mem_addr=%h, required %h (client %0d)",
                           cyc, bus.mem_addr, e.addr, e.client);
               end
               rdy_q.push_back('{e.client, e.addr, cyc + 1});
            end
         end else if (bus.mem_en !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_mem_en_x: cycle %0d mem_en=%b, required 0 or 1", cyc, bus.mem_en);
         end
         exp_rdy = '0;
         foreach (rdy_q[j])
            if (rdy_q[j].due == cyc) exp_rdy[rdy_q[j].client] = 1'b1;
         vectors++;
         if (bus.req_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL sb_ready: cycle %0d req_ready=%b, required %b", cyc, bus.req_ready, exp_rdy);
         end
         for (int j = rdy_q.size() - 1; j >= 0; j--) begin
            if (rdy_q[j].due + 1 == cyc) begin
               vectors++;
               if (bus.req_data !== mem_fn(rdy_q[j].addr)) begin
                  miscompares++;
                  $display("FAIL sb_data: cycle %0d client %0d req_data=%h, required %h",
                           cyc, rdy_q[j].client, bus.req_data, mem_fn(rdy_q[j].addr));
               end
               rdy_q.delete(j);
            end
         end
      end
   end

   // Advance one cycle; clients not in hold_mask drop their request once ready is seen.
   task automatic step();
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~(bus.req_ready & ~hold_mask);
   endtask

   task automatic check_en(input string name, input int k, input logic exp);
      @(negedge clk);
      vectors++;
      if (bus.mem_en !== exp) begin
         miscompares++;
         $display("FAIL %s: step %0d mem_en=%b, required %b", name, k, bus.mem_en, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_valid  = '1;
      bus1.req_valid = '0;
      bus1.req_addr  = '0;
      for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = AW'(16'h1000 + i);
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (bus.mem_en !== 1'b0 || bus.mem_addr !== '0 || bus.req_ready !== '0 ||
             bus1.mem_en !== 1'b0 || bus1.req_ready !== '0) begin
            miscompares++;
            $display("FAIL test_reset: mem_en=%b mem_addr=%h req_ready=%b l1_en=%b l1_ready=%b, required all 0",
                     bus.mem_en, bus.mem_addr, bus.req_ready, bus1.mem_en, bus1.req_ready);
         end
      end
   endtask

   task automatic test_all_clients();
      bit [0:5] exp_en = 6'b111100;
      for (int i = 0; i < N; i++) iss_q.push_back('{i, AW'(16'h1000 + i)});
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step();
         check_en("test_all_clients", k, exp_en[k]);
      end
      repeat (4) step();
   endtask

   task automatic test_single();
      bit [0:6] exp_en = 7'b1001000;
      bus.req_addr[1*AW +: AW] = 16'h0040;
      iss_q.push_back('{1, 16'h0040});
      iss_q.push_back('{1, 16'h0040});
      hold_mask = 4'b0010;
      step();
      bus.req_valid[1] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k == 4) hold_mask = '0;
         if (k > 0) step();
         check_en("test_single_en", k, exp_en[k]);
         if (k == 0 && bus.mem_addr !== 16'h0040) begin
            miscompares++;
            $display("FAIL test_single_addr: mem_addr=%h, required 0040", bus.mem_addr);
         end
         if (k == 1) begin
            vectors++;
            if (bus.req_ready !== 4'b0010) begin
               miscompares++;
               $display("FAIL test_single_ready: req_ready=%b, required 0010", bus.req_ready);
            end
         end
         if (k == 2) begin
            vectors++;
            if (bus.req_data !== 20'hABCDE) begin
               miscompares++;
               $display("FAIL test_single_data: req_data=%h, required abcde", bus.req_data);
            end
         end
      end
      repeat (3) step();
   endtask

   task automatic test_held_valid();
      bit [0:4] exp_en = 5'b10000;
      bus.req_addr[3*AW +: AW] = 16'h0333;
      iss_q.push_back('{3, 16'h0333});
      hold_mask = 4'b1000;
      step();
      bus.req_valid[3] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         if (k == 3) begin
            bus.req_valid[3] = 1'b0;
            hold_mask = '0;
         end
         check_en("test_held_valid", k, exp_en[k]);
      end
      repeat (3) step();
   endtask

   task automatic test_fairness();
      bit [0:9] exp_en = 10'b1101101100;
      bus.req_addr[0*AW +: AW] = 16'h2000;
      bus.req_addr[2*AW +: AW] = 16'h2002;
      for (int r = 0; r < 3; r++) begin
         iss_q.push_back('{0, 16'h2000});
         iss_q.push_back('{2, 16'h2002});
      end
      hold_mask = 4'b0101;
      step();
      bus.req_valid[0] = 1'b1;
      bus.req_valid[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) step();
         if (k == 8) begin
            bus.req_valid = '0;
            hold_mask = '0;
         end
         check_en("test_fairness", k, exp_en[k]);
      end
      repeat (4) step();
   endtask

   task automatic test_rr_wrap();
      bit [0:4] exp_en = 5'b11100;
      bus.req_addr[0*AW +: AW] = 16'h3000;
      bus.req_addr[1*AW +: AW] = 16'h3001;
      bus.req_addr[3*AW +: AW] = 16'h3003;
      iss_q.push_back('{3, 16'h3003});
      iss_q.push_back('{0, 16'h3000});
      iss_q.push_back('{1, 16'h3001});
      step();
      bus.req_valid = 4'b1011;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         check_en("test_rr_wrap", k, exp_en[k]);
      end
      repeat (4) step();
   endtask

   task automatic test_reset_mid();
      bit [0:6] exp_en = 7'b1000011;
      bus.req_addr[2*AW +: AW] = 16'h0222;
      iss_q.push_back('{2, 16'h0222});
      step();
      bus.req_valid[2] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) step();
         if (k == 1) begin
            rst = 1'b1;
            bus.req_valid = '0;
         end
         if (k == 3) rst = 1'b0;
         if (k == 5) begin
            bus.req_addr[2*AW +: AW] = 16'h0223;
            bus.req_addr[3*AW +: AW] = 16'h0334;
            iss_q.push_back('{2, 16'h0223});
            iss_q.push_back('{3, 16'h0334});
            bus.req_valid = 4'b1100;
         end
         check_en("test_reset_mid_en", k, exp_en[k]);
         if (k >= 1 && k <= 5) begin
            vectors++;
            if (bus.req_ready !== '0) begin
               miscompares++;
               $display("FAIL test_reset_mid_ready: step %0d req_ready=%b, required 0000", k, bus.req_ready);
            end
         end
      end
      repeat (4) step();
   endtask

   task automatic test_latency1();
      bit [0:3] exp_en  = 4'b1010;
      bit [0:3] exp_rdy = 4'b1010;
      bus1.req_addr[0 +: AW] = 16'h1234;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) bus1.req_valid[0] = 1'b1;
         if (k == 3) bus1.req_valid[0] = 1'b0;
         @(negedge clk);
         vectors++;
         if (bus1.mem_en !== exp_en[k] || bus1.req_ready !== {3'b000, exp_rdy[k]} ||
             (exp_en[k] && bus1.mem_addr !== 16'h1234)) begin
            miscompares++;
            $display("FAIL test_latency1: step %0d mem_en=%b req_ready=%b mem_addr=%h, required %b %b 1234",
                     k, bus1.mem_en, bus1.req_ready, bus1.mem_addr, exp_en[k], {3'b000, exp_rdy[k]});
         end
         if (k == 1 || k == 3) begin
            vectors++;
            if (bus1.req_data !== mem_fn(16'h1234)) begin
               miscompares++;
               $display("FAIL test_latency1_data: step %0d req_data=%h, required %h",
                        k, bus1.req_data, mem_fn(16'h1234));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_clients();
      test_single();
      test_held_valid();
      test_fairness();
      test_rr_wrap();
      test_reset_mid();
      test_latency1();
      repeat (2) step();
      vectors++;
      if (iss_q.size() != 0 || rdy_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d issues and %0d readies outstanding, required 0 and 0",
                  iss_q.size(), rdy_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
